mmu_resp_model: RTL
===================

MMU_RESP_MODEL -- requirements
Module: mmu_resp_model

Interface
REQ-001 SHALL have parameter VLEN, default riscv::VLEN, virtual address width.
REQ-002 SHALL have parameter PLEN, default riscv::PLEN, physical address width.
REQ-003 SHALL have ports, in order:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  1  accept new requests when high.
- resp_lat_i  in  6  response latency in cycles, 0..63.
- pa_offset_i  in  PLEN  offset added to the truncated vaddr to form paddr.
- fault_base_i  in  VLEN  page-fault match base.
- fault_mask_i  in  VLEN  page-fault match mask.
- acc_mmu_req_i  in  1  translation request, level.
- acc_mmu_vaddr_i  in  VLEN  virtual address.
- acc_mmu_is_store_i  in  1  request is from a store.
- acc_mmu_misaligned_ex_i  in  ariane_pkg::exception_t  requester-side misaligned exception.
- acc_mmu_valid_o  out  1  translation valid, one-cycle pulse.
- acc_mmu_paddr_o  out  PLEN  physical address.
- acc_mmu_exception_o  out  ariane_pkg::exception_t  translation exception.
- req_cnt_o  out  32  completed responses.
- fault_cnt_o  out  16  faulted responses.
- proto_err_o  out  1  sticky protocol-violation flag.

Function
REQ-004 SHALL implement FSM IDLE, WAIT, RESP; reset state IDLE.
REQ-005 IDLE: if en_i && acc_mmu_req_i in cycle T, SHALL latch vaddr, is_store, misaligned_ex, pa_offset_i and resp_lat_i, then go to WAIT (lat>0) or RESP (lat==0).
REQ-006 SHALL drive acc_mmu_valid_o high in exactly cycle T+1+lat, for one cycle (RESP state), then return to IDLE.
REQ-007 Outputs SHALL be registered; paddr and exception SHALL be zero whenever valid is low.
REQ-008 paddr SHALL be (vaddr[PLEN-1:0] + latched offset) mod 2^PLEN.
REQ-009 Page fault when (vaddr & fault_mask_i) == (fault_base_i & fault_mask_i), sampled at accept; exception.valid=1, cause=15 if is_store else 13, tval=vaddr zero-extended; paddr=0.
REQ-010 If latched misaligned_ex.valid, the response SHALL pass it through unchanged, paddr=0, with no fault check.
REQ-011 fault_mask_i == 0 SHALL fault every request; all-ones mask SHALL fault only vaddr == fault_base_i.
REQ-012 In the cycle after valid, the FSM SHALL be in IDLE; req high there SHALL start a new transaction.
REQ-013 req low during WAIT SHALL set proto_err_o, abort without valid, and return to IDLE.
REQ-014 vaddr change during WAIT with req high SHALL set proto_err_o; response SHALL use the latched vaddr.
REQ-015 en_i low mid-transaction SHALL NOT abort it; requests SHALL NOT be accepted while en_i is low.
REQ-016 resp_lat_i and pa_offset_i changes after accept SHALL NOT affect the in-flight transaction.
REQ-017 req_cnt_o SHALL increment per valid pulse and fault_cnt_o per faulted response (REQ-009 or REQ-010); both SHALL saturate at all-ones.

Reset
REQ-018 rst_i SHALL force IDLE and zero all outputs, counters, proto_err_o and latched state on the next edge, including mid-WAIT, with no valid issued.

Structure
REQ-019 Package mmu_resp_pkg SHALL hold the state enum and cause constants LOAD_PF=13, STORE_PF=15.
REQ-020 The saturating counter SHALL be sub-module mmu_resp_sat_cnt (parameterized width), instantiated twice.

Verification
REQ-021 lat=5, offset=0x1000, mask=0, vaddr=0x8000_0000 load -> valid at T+6, cause=13, tval=0x8000_0000, req_cnt=1, fault_cnt=1.
REQ-022 lat=0, mask=all-ones, base=0, vaddr=0x1234 store -> valid at T+1, paddr=0x2234 (offset 0x1000), exception.valid=0.
REQ-023 Back-to-back: req high again the cycle after valid, lat=2 -> second valid 3 cycles after re-accept; req_cnt=2.
REQ-024 req dropped at T+2 with lat=10 -> no valid ever, proto_err_o=1 until reset.
REQ-025 misaligned_ex.valid=1, cause=4 -> valid after lat with cause 4 passed through, paddr=0; rst_i mid-WAIT -> no valid, counters 0.

Source files
------------

// File: rtl/mmu_resp_pkg.sv
// Shared types and constants for the MMU response model.
package mmu_resp_pkg;

   // Local stand-ins for riscv::VLEN / riscv::PLEN (RV64 values).
   localparam int unsigned VLEN_DEFAULT = 64;
   localparam int unsigned PLEN_DEFAULT = 56;

   localparam int unsigned LOAD_PF  = 13;
   localparam int unsigned STORE_PF = 15;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic [63:0] pf_cause(input logic is_store);
      return is_store ? 64'(STORE_PF) : 64'(LOAD_PF);
   endfunction

endpackage

// File: rtl/mmu_resp_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module mmu_resp_sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mmu_resp_model.sv
// Behavioural MMU responder: accepts one translation at a time and answers
// after a programmable latency with a physical address or a page fault.
//
// state | meaning
// IDLE  | no transaction; accepts en_i && acc_mmu_req_i
// WAIT  | accepted, counting down the latched latency
// RESP  | acc_mmu_valid_o high for this single cycle
module mmu_resp_model
   import mmu_resp_pkg::*;
#(
   parameter int unsigned VLEN = VLEN_DEFAULT,
   parameter int unsigned PLEN = PLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [5:0]      resp_lat_i,
   input  logic [PLEN-1:0] pa_offset_i,
   input  logic [VLEN-1:0] fault_base_i,
   input  logic [VLEN-1:0] fault_mask_i,
   input  logic            acc_mmu_req_i,
   input  logic [VLEN-1:0] acc_mmu_vaddr_i,
   input  logic            acc_mmu_is_store_i,
   input  exception_t      acc_mmu_misaligned_ex_i,
   output logic            acc_mmu_valid_o,
   output logic [PLEN-1:0] acc_mmu_paddr_o,
   output exception_t      acc_mmu_exception_o,
   output logic [31:0]     req_cnt_o,
   output logic [15:0]     fault_cnt_o,
   output logic            proto_err_o
);

   state_e          state;
   logic [5:0]      lat_cnt;
   logic [VLEN-1:0] vaddr_q;
   logic [PLEN-1:0] paddr_q;
   exception_t      exc_q;

   logic            fault_hit;
   logic [PLEN-1:0] next_paddr;
   exception_t      next_exc;

   // The whole response is resolved at accept so later changes to the
   // offset, fault window or misaligned input cannot leak into it.
   always_comb begin
      fault_hit  = ((acc_mmu_vaddr_i & fault_mask_i) == (fault_base_i & fault_mask_i));
      next_paddr = '0;
      next_exc   = '0;
      if (acc_mmu_misaligned_ex_i.valid) begin
         next_exc = acc_mmu_misaligned_ex_i;
      end else if (fault_hit) begin
         next_exc.valid = 1'b1;
         next_exc.cause = pf_cause(acc_mmu_is_store_i);
         next_exc.tval  = 64'(acc_mmu_vaddr_i);
      end else begin
         next_paddr = PLEN'(acc_mmu_vaddr_i) + pa_offset_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state               <= ST_IDLE;
         lat_cnt             <= '0;
         vaddr_q             <= '0;
         paddr_q             <= '0;
         exc_q               <= '0;
         acc_mmu_valid_o     <= 1'b0;
         acc_mmu_paddr_o     <= '0;
         acc_mmu_exception_o <= '0;
         proto_err_o         <= 1'b0;
      end else begin
         acc_mmu_valid_o     <= 1'b0;
         acc_mmu_paddr_o     <= '0;
         acc_mmu_exception_o <= '0;
         case (state)
            ST_IDLE: begin
               if (en_i && acc_mmu_req_i) begin
                  vaddr_q <= acc_mmu_vaddr_i;
                  paddr_q <= next_paddr;
                  exc_q   <= next_exc;
                  lat_cnt <= resp_lat_i;
                  if (resp_lat_i == 6'd0) begin
                     state               <= ST_RESP;
                     acc_mmu_valid_o     <= 1'b1;
                     acc_mmu_paddr_o     <= next_paddr;
                     acc_mmu_exception_o <= next_exc;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!acc_mmu_req_i) begin
                  proto_err_o <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  if (acc_mmu_vaddr_i != vaddr_q) begin
                     proto_err_o <= 1'b1;
                  end
                  if (lat_cnt == 6'd1) begin
                     state               <= ST_RESP;
                     acc_mmu_valid_o     <= 1'b1;
                     acc_mmu_paddr_o     <= paddr_q;
                     acc_mmu_exception_o <= exc_q;
                  end else begin
                     lat_cnt <= lat_cnt - 6'd1;
                  end
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Counters advance at the end of the valid cycle.
   mmu_resp_sat_cnt #(.W(32)) u_req_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (acc_mmu_valid_o),
      .count (req_cnt_o)
   );

   mmu_resp_sat_cnt #(.W(16)) u_fault_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (acc_mmu_valid_o && acc_mmu_exception_o.valid),
      .count (fault_cnt_o)
   );

endmodule
